// File: rtl/logic_op_pipe_if.sv
// Request/result bundle for logic_op_pipe.
// The producer/consumer side uses master, the pipe uses slave.
interface logic_op_pipe_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CHW   = 2
);
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [2:0]             OP;
  logic [CHW-1:0]         CH;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic [WIDTH-1:0]       C;
  logic                   OUT_VALID;
  logic                   OUT_READY;
  logic [WIDTH-1:0]       OUT_DATA;
  logic [CHW-1:0]         OUT_CH;
  logic [NCH*WIDTH-1:0]   ACC;

  modport master (
    output IN_VALID, OP, CH, A, B, C,
    output OUT_READY,
    input  IN_READY, OUT_VALID,
    input  OUT_DATA, OUT_CH, ACC
  );

  modport slave (
    input  IN_VALID, OP, CH, A, B, C,
    input  OUT_READY,
    output IN_READY, OUT_VALID,
    output OUT_DATA, OUT_CH, ACC
  );
endinterface

// File: rtl/logic_op_pipe.sv
// Two-stage logic-op pipeline with per-channel
// sticky-OR accumulators and valid/ready flow.
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int FIELD = 2
) (
  input logic          CLK,
  input logic          RST,
  logic_op_pipe_if.slave bus
);

  typedef struct packed {
    logic [2:0]       op;
    logic [CHW-1:0]   ch;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } req_t;

  localparam logic [2:0] OP_OR    = 3'd0;
  localparam logic [2:0] OP_NOT   = 3'd1;
  localparam logic [2:0] OP_EQ    = 3'd2;
  localparam logic [2:0] OP_MUX   = 3'd3;
  localparam logic [2:0] OP_RAND  = 3'd4;
  localparam logic [2:0] OP_RANDF = 3'd5;
  localparam logic [2:0] OP_ACC   = 3'd6;
  localparam logic [2:0] OP_CLR   = 3'd7;

  logic                       stall;
  logic                       adv;

  logic                       s1_vld_q, s1_vld_d;
  req_t                       s1_q, s1_d;

  logic                       out_vld_q, out_vld_d;
  logic [WIDTH-1:0]           out_data_q, out_data_d;
  logic [CHW-1:0]             out_ch_q, out_ch_d;

  logic [NCH-1:0][WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]           acc_sel;
  logic [WIDTH-1:0]           res;

  assign stall = out_vld_q & ~bus.OUT_READY;
  assign adv   = ~stall;

  assign bus.IN_READY  = adv;
  assign bus.OUT_VALID = out_vld_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_CH    = out_ch_q;
  assign bus.ACC       = acc_q;

  assign acc_sel = acc_q[s1_q.ch];

  // Stage-2 result for the request held in stage 1.
  always_comb begin
    res = '0;
    case (s1_q.op)
      OP_OR:    res = s1_q.a | s1_q.b;
      OP_NOT:   res = ~s1_q.b;
      OP_EQ:    res = {{(WIDTH-1){1'b0}},
                       (s1_q.a == s1_q.b)};
      OP_MUX:   res = (|s1_q.b) ? s1_q.a
                                : s1_q.c;
      OP_RAND:  res = {{(WIDTH-1){1'b0}},
                       (&s1_q.a)};
      OP_RANDF: res = {{(WIDTH-1){1'b0}},
                       (&s1_q.a[FIELD-1:0])};
      OP_ACC:   res = acc_sel | s1_q.a;
      OP_CLR:   res = '0;
      default:  res = '0;
    endcase
  end

  // Both stages and the accumulators move together unless stalled.
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_d       = s1_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    acc_d      = acc_q;
    if (adv) begin
      s1_vld_d = bus.IN_VALID;
      if (bus.IN_VALID) begin
        s1_d.op = bus.OP;
        s1_d.ch = bus.CH;
        s1_d.a  = bus.A;
        s1_d.b  = bus.B;
        s1_d.c  = bus.C;
      end
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_data_d = res;
        out_ch_d   = s1_q.ch;
        if (s1_q.op == OP_ACC)
          acc_d[s1_q.ch] = res;
        if (s1_q.op == OP_CLR)
          acc_d[s1_q.ch] = '0;
      end
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_vld_q   <= 1'b0;
      s1_q       <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      acc_q      <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_q       <= s1_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Randomized and directed bench for logic_op_pipe
// against a queue-based reference model.
module tb_logic_op_pipe;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int F  = 2;
  localparam logic [7:0] FMASK = 8'((1 << F) - 1);

  logic CLK;
  logic RST;

  logic_op_pipe_if #(.WIDTH(W), .NCH(N), .CHW(CW)) bus ();

  logic_op_pipe #(
    .WIDTH(W), .NCH(N), .CHW(CW), .FIELD(F)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  ch;
    logic [31:0] acc;
    int          acc_cyc;
    bit          has_lit;
    logic [7:0]  lit;
  } exp_t;

  exp_t       q[$];
  bit         head_seen;
  logic [7:0] macc[N];
  int         cyc;
  int         vectors;
  int         miscompares;
  bit         rand_mode;
  bit         lat_check;
  bit         cur_hl;
  logic [7:0] cur_lit;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_acc();
    return {macc[3], macc[2], macc[1], macc[0]};
  endfunction

  function automatic logic [7:0] model(
    input logic [2:0] op, input logic [1:0] ch,
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c);
    case (op)
      3'd0: return a | b;
      3'd1: return 8'hFF ^ b;
      3'd2: return (a == b) ? 8'd1 : 8'd0;
      3'd3: return (b != 0) ? a : c;
      3'd4: return (a == 8'hFF) ? 8'd1 : 8'd0;
      3'd5: return ((a & FMASK) == FMASK) ? 8'd1 : 8'd0;
      3'd6: return macc[ch] | a;
      default: return 8'd0;
    endcase
  endfunction

  task automatic monitor();
    bit         ps;
    logic       pv;
    logic [7:0] pd;
    logic [1:0] pc;
    logic       st;
    exp_t       e;
    ps = 0;
    pv = 0;
    pd = 0;
    pc = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        q.delete();
        head_seen = 0;
        for (int k = 0; k < N; k++) macc[k] = 0;
        ps = 0;
        chk("rst_out_valid", bus.OUT_VALID, 0);
        chk("rst_out_data", bus.OUT_DATA, 0);
        chk("rst_acc", bus.ACC, 0);
        chk("rst_in_ready", bus.IN_READY, 1);
      end else begin
        st = bus.OUT_VALID && !bus.OUT_READY;
        chk("in_ready", bus.IN_READY, !st);
        if (ps) begin
          chk("hold_valid", bus.OUT_VALID, pv);
          chk("hold_data", bus.OUT_DATA, pd);
          chk("hold_ch", bus.OUT_CH, pc);
        end
        if (bus.OUT_VALID) begin
          chk("out_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            if (!head_seen) begin
              head_seen = 1;
              chk("data", bus.OUT_DATA, q[0].d);
              chk("out_ch", bus.OUT_CH, q[0].ch);
              chk("acc_at_out", bus.ACC, q[0].acc);
              if (q[0].has_lit)
                chk("lit_data", bus.OUT_DATA, q[0].lit);
              if (lat_check)
                chk("latency", cyc - q[0].acc_cyc, 1);
            end
            if (bus.OUT_READY) begin
              void'(q.pop_front());
              head_seen = 0;
            end
          end
        end
        if (bus.IN_VALID && bus.IN_READY) begin
          e.d = model(bus.OP, bus.CH,
                      bus.A, bus.B, bus.C);
          if (bus.OP == 3'd6) macc[bus.CH] = e.d;
          if (bus.OP == 3'd7) macc[bus.CH] = 0;
          e.ch      = bus.CH;
          e.acc     = pack_acc();
          e.acc_cyc = cyc + 1;
          e.has_lit = cur_hl;
          e.lit     = cur_lit;
          q.push_back(e);
        end
        ps = st;
        pv = bus.OUT_VALID;
        pd = bus.OUT_DATA;
        pc = bus.OUT_CH;
      end
    end
  endtask

  task automatic rnd_ready();
    forever begin
      @(posedge CLK);
      #1;
      if (rand_mode)
        bus.OUT_READY = ($urandom % 4) != 0;
    end
  endtask

  task automatic send(input logic [2:0] op,
                      input logic [1:0] ch,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] c,
                      input bit hl,
                      input logic [7:0] lit);
    bit r;
    bit ok;
    ok = 0;
    bus.IN_VALID = 1;
    bus.OP = op;
    bus.CH = ch;
    bus.A  = a;
    bus.B  = b;
    bus.C  = c;
    cur_hl  = hl;
    cur_lit = lit;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      r = bus.IN_READY;
      @(posedge CLK);
      #1;
      if (r) begin
        ok = 1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    bus.IN_VALID = 0;
    cur_hl = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    rand_mode = 0;
    bus.OUT_READY = 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #2;
      if (q.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk("drain_timeout", done, 1);
    chk("drained_valid", bus.OUT_VALID, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    head_seen = 0;
    rand_mode = 0;
    lat_check = 1;
    cur_hl = 0;
    cur_lit = 0;
    for (int k = 0; k < N; k++) macc[k] = 0;
    RST = 1;
    bus.IN_VALID = 0;
    bus.OP = 0;
    bus.CH = 0;
    bus.A = 0;
    bus.B = 0;
    bus.C = 0;
    bus.OUT_READY = 1;

    fork
      monitor();
      rnd_ready();
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge CLK);
    #1 RST = 0;

    send(3'd0, 0, 8'hF0, 8'h0F, 8'h55, 1, 8'hFF);
    send(3'd1, 0, 8'hF0, 8'h0F, 8'h55, 1, 8'hF0);
    send(3'd2, 0, 8'hF0, 8'h0F, 8'h55, 1, 8'h00);
    send(3'd3, 0, 8'hF0, 8'h0F, 8'h55, 1, 8'hF0);
    send(3'd4, 0, 8'hF0, 8'h0F, 8'h55, 1, 8'h00);
    send(3'd5, 0, 8'hF0, 8'h0F, 8'h55, 1, 8'h00);
    send(3'd3, 0, 8'hFF, 8'h00, 8'h3C, 1, 8'h3C);
    send(3'd4, 0, 8'hFF, 8'h00, 8'h00, 1, 8'h01);
    send(3'd5, 0, 8'h03, 8'h00, 8'h00, 1, 8'h01);
    send(3'd2, 0, 8'hA5, 8'hA5, 8'h00, 1, 8'h01);
    send(3'd6, 2, 8'h01, 8'h00, 8'h00, 1, 8'h01);
    send(3'd6, 2, 8'h80, 8'h00, 8'h00, 1, 8'h81);
    drain();
    chk("acc_ch2_81", bus.ACC, 32'h0081_0000);
    send(3'd7, 2, 8'h00, 8'h00, 8'h00, 1, 8'h00);
    drain();
    chk("acc_cleared", bus.ACC, 32'h0);

    lat_check = 0;
    fork
      begin
        send(3'd0, 1, 8'h01, 8'h02, 8'h00, 1, 8'h03);
        send(3'd0, 2, 8'h04, 8'h08, 8'h00, 1, 8'h0C);
        send(3'd0, 3, 8'h10, 8'h20, 8'h00, 1, 8'h30);
        send(3'd0, 0, 8'h40, 8'h80, 8'h00, 1, 8'hC0);
      end
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge CLK);
          if (bus.OUT_VALID) begin
            seen = 1;
            break;
          end
        end
        chk("bp_first_result", seen, 1);
        @(posedge CLK);
        #1 bus.OUT_READY = 0;
        repeat (3) @(posedge CLK);
        #1 bus.OUT_READY = 1;
      end
    join
    drain();

    lat_check = 1;
    send(3'd6, 1, 8'hFF, 8'h00, 8'h00, 0, 8'h00);
    RST = 1;
    bus.IN_VALID = 1;
    bus.OP = 3'd0;
    bus.A = 8'h55;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    bus.IN_VALID = 0;
    chk("post_rst_valid", bus.OUT_VALID, 0);
    chk("post_rst_acc", bus.ACC, 32'h0);
    send(3'd0, 0, 8'h12, 8'h21, 8'h00, 1, 8'h33);
    drain();
    chk("post_rst_acc_final", bus.ACC, 32'h0);

    lat_check = 0;
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 4) == 0) begin
        @(posedge CLK);
        #1;
      end
      send(3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom),
           8'($urandom), 0, 8'h00);
    end
    drain();
    chk("final_acc", bus.ACC, pack_acc());

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_op_pipe.md
LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (>=2).
REQ-002 SHALL have parameter NCH, default 4, meaning number of sticky-OR accumulator channels (power of two, >=2).
REQ-003 SHALL have parameter CHW, default 2, meaning channel index width, equal to log2(NCH).
REQ-004 SHALL have parameter FIELD, default 2, meaning low-bit field width for partial reduction (1..WIDTH).
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port IN_VALID  input  1  request valid.
REQ-008 SHALL have port IN_READY  output  1  request accepted when IN_VALID and IN_READY are both high at a rising CLK edge.
REQ-009 SHALL have port OP  input  3  opcode, per REQ-016.
REQ-010 SHALL have port CH  input  CHW  accumulator channel for opcodes 6 and 7.
REQ-011 SHALL have ports A, B, C  input  WIDTH each  operands.
REQ-012 SHALL have port OUT_VALID  output  1  result valid.
REQ-013 SHALL have port OUT_READY  input  1  consumer ready; result transfers when OUT_VALID and OUT_READY are both high at an edge.
REQ-014 SHALL have ports OUT_DATA  output  WIDTH  result, and OUT_CH  output  CHW  CH of the producing request.
REQ-015 SHALL have port ACC  output  NCH*WIDTH  accumulator contents, channel k at bits [k*WIDTH +: WIDTH].

Function
REQ-016 SHALL compute per opcode: 0 OR = A|B; 1 NOT = ~B; 2 EQ = zero-extended (A==B); 3 MUX = (|B) ? A : C; 4 RAND = zero-extended &A; 5 RANDF = zero-extended &A[FIELD-1:0]; 6 ACC = acc[CH] | A, written to acc[CH]; 7 CLR = 0, acc[CH] set to 0.
REQ-017 SHALL be a two-stage pipeline: stage 1 registers OP/CH/A/B/C with a valid bit; stage 2 computes and registers OUT_DATA/OUT_CH/OUT_VALID.
REQ-018 SHALL define stall = OUT_VALID && !OUT_READY; both stages hold when stall is high and advance otherwise.
REQ-019 SHALL drive IN_READY = !stall combinationally; no request dropped or duplicated.
REQ-020 SHALL give latency two edges: request accepted at edge n with no stall -> OUT_VALID high after edge n+1.
REQ-021 SHALL sustain one request per cycle while OUT_READY stays high.
REQ-022 SHALL hold OUT_DATA, OUT_CH, OUT_VALID stable while stall is high.
REQ-023 SHALL update acc[CH] for opcodes 6/7 only at the edge where the request moves from stage 1 into stage 2, using acc value at that edge; back-to-back ACC/CLR on the same channel therefore see each prior update.
REQ-024 SHALL leave other channels' accumulators unchanged on any ACC/CLR.
REQ-025 SHALL clear stage-1 valid when stage 1 advances with no new request (bubble); bubbles produce no OUT_VALID and no accumulator change.
REQ-026 SHALL keep all arithmetic at WIDTH bits; no carries, no sign handling.

Reset
REQ-027 SHALL, while RST is high, asynchronously clear both stage valid bits, OUT_VALID, OUT_DATA, OUT_CH and all accumulators to 0.
REQ-028 SHALL drive IN_READY high during reset (stall is 0); requests presented during reset are not accepted.
REQ-029 SHALL discard in-flight requests on reset assertion mid-operation; no partial accumulator update survives.
REQ-030 SHALL accept the first request at the first rising edge after RST deasserts.

Verification (WIDTH=8, NCH=4, FIELD=2)
REQ-031 SHALL cover opcode sweep, OUT_READY=1: A=8'hF0,B=8'h0F,C=8'h55 for OP 0..5 -> OUT_DATA FF, F0, 00, F0, 00, 00, each two edges after acceptance.
REQ-032 SHALL cover MUX/reduction: B=0,A=8'hFF,C=8'h3C OP3 -> 3C; A=8'hFF OP4 -> 01; A=8'h03 OP5 -> 01; A=B=8'hA5 OP2 -> 01.
REQ-033 SHALL cover accumulator: ACC ch2 A=01, ACC ch2 A=80 back-to-back -> OUT_DATA 01 then 81, ACC[23:16]=81, other channels 00; CLR ch2 -> OUT_DATA 00, ACC[23:16]=00.
REQ-034 SHALL cover backpressure: stream 4 requests, OUT_READY low 3 cycles after first result -> IN_READY low those cycles, OUT_DATA held, all 4 results delivered in order once.
REQ-035 SHALL cover reset mid-operation: ACC ch1 A=FF accepted, RST pulsed before it reaches stage 2 -> OUT_VALID 0, ACC all 0, next request output normally.
